// File: rtl/mlp_pkg.sv
// Shared definitions for the ADC-to-MLP front end: default frame geometry,
// drop counter width and the frame buffer state encoding.
package mlp_pkg;

  localparam int DEF_INPUT_BIT = 6;
  localparam int DEF_INPUT_NUM = 5;
  localparam int DROP_CNT_W    = 16;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } frame_state_t;

endpackage

// File: rtl/adc_offset_sat.sv
// Combinational ADC offset removal: adj_code = raw_code - offset_code,
// clamped at zero so codes below the offset never wrap to large values.
// Only instantiated when ADC_FRAME_OFFSET_EN is defined.
module adc_offset_sat
  import mlp_pkg::*;
#(
  parameter int INPUT_BIT = DEF_INPUT_BIT
) (
  input  logic [INPUT_BIT-1:0] raw_code,
  input  logic [INPUT_BIT-1:0] offset_code,
  output logic [INPUT_BIT-1:0] adj_code
);

  // Subtract with a floor at zero.
  always_comb begin
    adj_code = '0;
    if (raw_code > offset_code) begin
      adj_code = raw_code - offset_code;
    end else begin
      adj_code = '0;
    end
  end

endmodule

// File: rtl/adc_frame_buffer.sv
// Collects ADC samples into sliding frames of INPUT_NUM codes for the MLP.
// A new frame is issued every STRIDE accepted samples once the window is full.
// Samples arriving while a frame waits for the MLP are dropped and counted.
// Optional macro ADC_FRAME_OFFSET_EN adds offset_code and stores
// max(s_data - offset_code, 0) instead of the raw code.
module adc_frame_buffer
  import mlp_pkg::*;
#(
  parameter int INPUT_BIT = DEF_INPUT_BIT,
  parameter int INPUT_NUM = DEF_INPUT_NUM,
  parameter int STRIDE    = 1
) (
  input  logic                           clk,
  input  logic                           arstb,
  input  logic                           clr,
  input  logic                           s_valid,
  input  logic [INPUT_BIT-1:0]           s_data,
`ifdef ADC_FRAME_OFFSET_EN
  input  logic [INPUT_BIT-1:0]           offset_code,
`endif
  output logic                           s_ready,
  output logic                           m_valid,
  output logic [INPUT_NUM*INPUT_BIT-1:0] m_data,
  input  logic                           m_ready,
  output logic [DROP_CNT_W-1:0]          drop_cnt
);

  localparam int FILL_W = $clog2(INPUT_NUM + 1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(INPUT_NUM);
  localparam logic [FILL_W-1:0]     FILL_KEEP = FILL_W'(INPUT_NUM - STRIDE);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};

  frame_state_t          state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_base_s;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [INPUT_BIT-1:0]  slot_q [INPUT_NUM];
  logic [INPUT_BIT-1:0]  slot_d [INPUT_NUM];
  logic [INPUT_BIT-1:0]  sample_s;
  logic                  accept_s, drop_s, handshake_s;

`ifdef ADC_FRAME_OFFSET_EN
  adc_offset_sat #(
    .INPUT_BIT (INPUT_BIT)
  ) u_offset (
    .raw_code    (s_data),
    .offset_code (offset_code),
    .adj_code    (sample_s)
  );
`else
  assign sample_s = s_data;
`endif

  // Handshake decode; the shift register always holds the newest samples,
  // so retention on a frame handshake only rewinds the fill count.
  always_comb begin
    s_ready     = (state_q == FILL) || m_ready;
    m_valid     = (state_q == HOLD);
    accept_s    = s_valid && s_ready;
    drop_s      = s_valid && !s_ready;
    handshake_s = m_valid && m_ready;
    drop_cnt    = drop_q;
  end

  // Next-state, fill count, drop counter and sample shift (clr wins over all).
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    drop_d      = drop_q;
    fill_base_s = fill_q;
    for (int i = 0; i < INPUT_NUM; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (clr) begin
      state_d = FILL;
      fill_d  = '0;
      drop_d  = '0;
    end else begin
      if (drop_s && (drop_q != DROP_MAX)) begin
        drop_d = drop_q + DROP_CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
      if (handshake_s) begin
        fill_base_s = FILL_KEEP;
      end else begin
        fill_base_s = fill_q;
      end
      if (accept_s) begin
        fill_d = fill_base_s + FILL_W'(1);
        for (int i = 0; i < INPUT_NUM - 1; i++) begin
          slot_d[i] = slot_q[i+1];
        end
        slot_d[INPUT_NUM-1] = sample_s;
      end else begin
        fill_d = fill_base_s;
      end
      case (fill_d == FILL_FULL)
        1'b1:    state_d = HOLD;
        1'b0:    state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // State, counters and sample storage; reset clears everything including slots.
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      state_q <= FILL;
      fill_q  <= '0;
      drop_q  <= '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      drop_q  <= drop_d;
      for (int i = 0; i < INPUT_NUM; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Frame output: slot 0 holds the oldest sample and lands in the LSBs.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      m_data[i*INPUT_BIT +: INPUT_BIT] = slot_q[i];
    end
  end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Scoreboard bench for adc_frame_buffer: a STRIDE=1 and a STRIDE=5 instance.
// Expected frames are queued at stimulus time; monitors pop on each handshake.
module tb_adc_frame_buffer;

  logic        clk = 1'b0;
  logic        arstb = 1'b0;
  logic        clr1 = 1'b0, s_valid1 = 1'b0, m_ready1 = 1'b0;
  logic [5:0]  s_data1 = 6'd0;
  logic        s_ready1, m_valid1;
  logic [29:0] m_data1;
  logic [15:0] drop1;
  logic        clr5 = 1'b0, s_valid5 = 1'b0, m_ready5 = 1'b0;
  logic [5:0]  s_data5 = 6'd0;
  logic        s_ready5, m_valid5;
  logic [29:0] m_data5;
  logic [15:0] drop5;
`ifdef ADC_FRAME_OFFSET_EN
  logic [5:0]  offset1 = 6'd0;
`endif

  logic [29:0] q1[$];
  logic [29:0] q5[$];
  int total = 0, passed = 0;
  int frames1 = 0, frames5 = 0, exp_frames1 = 0;

  always #5 clk = ~clk;

  adc_frame_buffer #(.INPUT_BIT(6), .INPUT_NUM(5), .STRIDE(1)) u1 (
    .clk(clk), .arstb(arstb), .clr(clr1), .s_valid(s_valid1), .s_data(s_data1),
`ifdef ADC_FRAME_OFFSET_EN
    .offset_code(offset1),
`endif
    .s_ready(s_ready1), .m_valid(m_valid1), .m_data(m_data1),
    .m_ready(m_ready1), .drop_cnt(drop1)
  );

  adc_frame_buffer #(.INPUT_BIT(6), .INPUT_NUM(5), .STRIDE(5)) u5 (
    .clk(clk), .arstb(arstb), .clr(clr5), .s_valid(s_valid5), .s_data(s_data5),
`ifdef ADC_FRAME_OFFSET_EN
    .offset_code(6'd0),
`endif
    .s_ready(s_ready5), .m_valid(m_valid5), .m_data(m_data5),
    .m_ready(m_ready5), .drop_cnt(drop5)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Newest sample first (MSBs), oldest last (LSBs).
  function automatic logic [29:0] fr(input int a, input int b, input int c, input int d, input int e);
    logic [5:0] va, vb, vc, vd, ve;
    va = 6'(a); vb = 6'(b); vc = 6'(c); vd = 6'(d); ve = 6'(e);
    return {va, vb, vc, vd, ve};
  endfunction

  task automatic send1(input int d);
    s_valid1 = 1'b1; s_data1 = 6'(d);
    @(posedge clk); #1;
    s_valid1 = 1'b0;
  endtask

  task automatic send5(input int d);
    s_valid5 = 1'b1; s_data5 = 6'(d);
    @(posedge clk); #1;
    s_valid5 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr1();
    clr1 = 1'b1;
    @(posedge clk); #1;
    clr1 = 1'b0;
  endtask

  // Monitor for the STRIDE=1 instance.
  always @(negedge clk) begin
    if (m_valid1 && m_ready1) begin
      frames1++;
      if (q1.size() == 0) begin
        total++;
        $display("FAIL u1_frame: got unexpected frame %0h expected none", m_data1);
      end else begin
        check("u1_frame", 64'(m_data1), 64'(q1.pop_front()));
      end
    end
  end

  // Monitor for the STRIDE=5 instance.
  always @(negedge clk) begin
    if (m_valid5 && m_ready5) begin
      frames5++;
      if (q5.size() == 0) begin
        total++;
        $display("FAIL u5_frame: got unexpected frame %0h expected none", m_data5);
      end else begin
        check("u5_frame", 64'(m_data5), 64'(q5.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_m_valid", 64'(m_valid1), 64'd0);
    check("rst_m_data", 64'(m_data1), 64'd0);
    check("rst_drop", 64'(drop1), 64'd0);
    check("rst_s_ready", 64'(s_ready1), 64'd1);
    #10 arstb = 1'b1;
    idle(1);
    check("post_rst_s_ready", 64'(s_ready1), 64'd1);

    // Block mode, STRIDE=5: exactly two frames from 1..10
    q5.push_back(fr(5, 4, 3, 2, 1));
    q5.push_back(fr(10, 9, 8, 7, 6));
    m_ready5 = 1'b1;
    for (int i = 1; i <= 10; i++) send5(i);
    idle(3);
    m_ready5 = 1'b0;
    check("u5_frame_count", 64'(frames5), 64'd2);
    check("u5_drop", 64'(drop5), 64'd0);

    // Fill, STRIDE=1, m_ready=0
    for (int i = 1; i <= 4; i++) send1(i);
    check("fill_not_valid", 64'(m_valid1), 64'd0);
    send1(5);
    check("fill_valid", 64'(m_valid1), 64'd1);
    check("fill_data", 64'(m_data1), 64'(fr(5, 4, 3, 2, 1)));
    check("fill_s_ready_low", 64'(s_ready1), 64'd0);
    send1(6);
    check("fill_drop", 64'(drop1), 64'd1);
    check("fill_data_stable", 64'(m_data1), 64'(fr(5, 4, 3, 2, 1)));
    q1.push_back(fr(5, 4, 3, 2, 1)); exp_frames1++;
    m_ready1 = 1'b1;
    idle(1);
    m_ready1 = 1'b0;
    check("fill_release", 64'(m_valid1), 64'd0);

    // Sliding, STRIDE=1, m_ready held high
    pulse_clr1();
    check("clr_drop", 64'(drop1), 64'd0);
    q1.push_back(fr(5, 4, 3, 2, 1));
    q1.push_back(fr(6, 5, 4, 3, 2));
    q1.push_back(fr(7, 6, 5, 4, 3));
    q1.push_back(fr(8, 7, 6, 5, 4));
    exp_frames1 += 4;
    m_ready1 = 1'b1;
    for (int i = 1; i <= 8; i++) send1(i);
    idle(2);
    m_ready1 = 1'b0;
    check("slide_drop", 64'(drop1), 64'd0);
    check("slide_frames", 64'(frames1), 64'(exp_frames1));

    // Clear after 3 samples; sample in clr cycle discarded and not counted
    pulse_clr1();
    for (int i = 11; i <= 13; i++) send1(i);
    clr1 = 1'b1; s_valid1 = 1'b1; s_data1 = 6'd63;
    @(posedge clk); #1;
    clr1 = 1'b0; s_valid1 = 1'b0;
    check("clr_cycle_drop", 64'(drop1), 64'd0);
    for (int i = 21; i <= 24; i++) send1(i);
    check("clr_4_no_frame", 64'(m_valid1), 64'd0);
    send1(25);
    check("clr_5_frame", 64'(m_valid1), 64'd1);
    check("clr_frame_data", 64'(m_data1), 64'(fr(25, 24, 23, 22, 21)));

    // Reset mid-HOLD
    arstb = 1'b0;
    #1;
    check("arst_m_valid", 64'(m_valid1), 64'd0);
    check("arst_m_data", 64'(m_data1), 64'd0);
    check("arst_s_ready", 64'(s_ready1), 64'd1);
    @(posedge clk); #1;
    arstb = 1'b1;
    for (int i = 31; i <= 34; i++) send1(i);
    check("arst_4_no_frame", 64'(m_valid1), 64'd0);
    send1(35);
    check("arst_5_frame", 64'(m_valid1), 64'd1);
    q1.push_back(fr(35, 34, 33, 32, 31)); exp_frames1++;
    m_ready1 = 1'b1;
    idle(1);
    m_ready1 = 1'b0;

`ifdef ADC_FRAME_OFFSET_EN
    // Offset subtraction with clamp
    pulse_clr1();
    offset1 = 6'd10;
    send1(4); send1(12); send1(63); send1(10); send1(11);
    check("offset_data", 64'(m_data1), 64'(fr(1, 0, 53, 2, 0)));
    q1.push_back(fr(1, 0, 53, 2, 0)); exp_frames1++;
    m_ready1 = 1'b1;
    idle(1);
    m_ready1 = 1'b0;
    offset1 = 6'd0;
`endif

    // Saturation: hold a frame and flood 70000 samples
    send1(40);
    check("sat_hold", 64'(m_valid1), 64'd1);
    s_valid1 = 1'b1; s_data1 = 6'd7;
    idle(65534);
    check("sat_fffe", 64'(drop1), 64'hFFFE);
    idle(1);
    check("sat_ffff", 64'(drop1), 64'hFFFF);
    idle(4465);
    s_valid1 = 1'b0;
    check("sat_no_wrap", 64'(drop1), 64'hFFFF);

    // Final scoreboard accounting
    check("q1_empty", 64'(q1.size()), 64'd0);
    check("q5_empty", 64'(q5.size()), 64'd0);
    check("u1_frame_total", 64'(frames1), 64'(exp_frames1));
    check("u5_frame_total", 64'(frames5), 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_frame_buffer.md
ADC_FRAME_BUFFER -- requirements
Module: adc_frame_buffer

Interface
REQ-001 SHALL have parameter INPUT_BIT, default 6: ADC code width in bits.
REQ-002 SHALL have parameter INPUT_NUM, default 5: samples per frame, equal to the MLP input count.
REQ-003 SHALL have parameter STRIDE, default 1: new samples required between frames; legal range 1..INPUT_NUM.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have port arstb, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 SHALL have port s_valid, input, 1 bit: ADC sample present.
REQ-008 SHALL have port s_data, input, INPUT_BIT bits: ADC sample code, unsigned.
REQ-009 SHALL have port s_ready, output, 1 bit: sample is accepted this cycle.
REQ-010 SHALL have port m_valid, output, 1 bit: frame available to the MLP.
REQ-011 SHALL have port m_data, output, INPUT_NUM*INPUT_BIT bits: frame with the oldest sample in the LSBs.
REQ-012 SHALL have port m_ready, input, 1 bit: MLP takes the frame.
REQ-013 SHALL have port drop_cnt, output, 16 bits: count of dropped samples.

Function
REQ-014 SHALL implement a two-state FSM: FILL, then HOLD.
REQ-015 SHALL hold a fill count in the range 0..INPUT_NUM.
REQ-016 SHALL store samples in an INPUT_NUM-deep shift register; an accepted sample enters at the newest slot.
REQ-017 SHALL drive s_ready = (state==FILL) || m_ready, combinationally.
REQ-018 SHALL accept a sample when s_valid && s_ready.
REQ-019 SHALL drop a sample when s_valid && !s_ready, and increment drop_cnt.
  - Upstream cannot stall; the dropped sample is not stored.
REQ-020 SHALL saturate drop_cnt at 16'hFFFF; it SHALL NOT wrap.
REQ-021 In FILL, an accept that makes fill==INPUT_NUM SHALL enter HOLD and assert m_valid on that same clock edge.
  - Latency: one clock from the completing sample to m_valid.
REQ-022 SHALL drive m_valid = (state==HOLD), registered.
REQ-023 SHALL hold m_data stable while m_valid && !m_ready.
REQ-024 On the handshake m_valid && m_ready, SHALL retain the newest INPUT_NUM-STRIDE samples and set fill=INPUT_NUM-STRIDE.
  - With no simultaneous accept: state FILL.
REQ-025 On a handshake with a simultaneous accept, SHALL apply retention first, then append the new sample.
  - fill = INPUT_NUM-STRIDE+1.
  - If that equals INPUT_NUM (STRIDE=1): stay in HOLD, m_valid stays high, and the new frame appears next cycle.
REQ-026 SHALL never raise fill above INPUT_NUM and never issue a frame with fill<INPUT_NUM.
REQ-027 clr SHALL take priority over every handshake in the same cycle.
  - Effect: fill=0, state FILL, drop_cnt=0; sample storage unchanged.
  - A sample presented in the clr cycle is discarded and not counted.

Reset
REQ-028 While arstb is low, SHALL force:
  - state FILL, fill 0;
  - m_valid 0, drop_cnt 0;
  - all sample slots 0, so m_data 0.
REQ-029 Reset mid-frame SHALL discard partial and pending frames; no frame is issued after release until INPUT_NUM new samples are accepted.
REQ-030 s_ready SHALL read 1 during and after reset.

Configuration
REQ-031 SHALL support macro ADC_FRAME_OFFSET_EN.
  - Defined: adds input port offset_code, INPUT_BIT bits; stored sample = s_data - offset_code, clamped at 0.
  - Undefined: port absent; stored sample = s_data unchanged.
  - Timing and handshake SHALL be identical in both builds.

Structure
REQ-032 Package mlp_pkg SHALL hold:
  - default INPUT_BIT and INPUT_NUM;
  - DROP_CNT_W=16;
  - typedef enum frame_state_t {FILL, HOLD}.
REQ-033 Offset subtraction SHALL be the sub-module adc_offset_sat, combinational, instantiated only under ADC_FRAME_OFFSET_EN.

Verification
REQ-034 Fill: STRIDE=1; feed 1,2,3,4,5 on consecutive cycles, m_ready=0 -> m_valid rises the cycle after 5, m_data={5,4,3,2,1}, and 6 at that cycle is dropped with drop_cnt=1.
REQ-035 Sliding: STRIDE=1 with m_ready=1 continuously; feed 1..8 -> frames {5..1}, {6..2}, {7..3}, {8..4} on consecutive cycles, no drops.
REQ-036 Block: STRIDE=5; feed 1..10 with m_ready=1 -> exactly two frames, {5..1} and {10..6}.
REQ-037 Saturation: hold m_valid with m_ready=0 and feed 70000 samples -> drop_cnt=16'hFFFF.
REQ-038 Clear and reset: assert clr after 3 samples -> fill restarts and 5 further samples are needed for a frame; arstb low mid-HOLD -> m_valid=0 and m_data=0 immediately.
REQ-039 Offset: with ADC_FRAME_OFFSET_EN and offset_code=10, feed 4,12,63,10,11 -> m_data={1,0,53,2,0}.
